// File: rtl/ddr_arb_pkg.sv
// Shared constants for the two-port DDR user-port arbiter: bus/timeout defaults
// and the FSM state encoding.
package ddr_arb_pkg;

    localparam int ARB_ADDR_W      = 28;
    localparam int ARB_DATA_W      = 32;
    localparam int ARB_TIMEOUT_CYC = 1023;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to the
// requester that was not served last.
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req_valid;
        if (&req_valid) begin
            gnt_idx = ~last_grant;
        end else begin
            gnt_idx = req_valid[1];
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR controller user port between the CPU (m0) and the UART loader (m1),
// with a single outstanding transaction and a response timeout.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                sys_resetn,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic                m0_req_we,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic [DATA_W/8-1:0] m0_req_wstrb,
    output logic                m0_rsp_valid,
    output logic [DATA_W-1:0]   m0_rsp_rdata,
    output logic                m0_rsp_err,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic                m1_req_we,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_wstrb,
    output logic                m1_rsp_valid,
    output logic [DATA_W-1:0]   m1_rsp_rdata,
    output logic                m1_rsp_err,

    output logic                mem_cmd_valid,
    input  logic                mem_cmd_ready,
    output logic                mem_cmd_we,
    output logic [ADDR_W-1:0]   mem_cmd_addr,
    output logic [DATA_W-1:0]   mem_cmd_wdata,
    output logic [DATA_W/8-1:0] mem_cmd_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,

    output logic                busy
);

    localparam int                TIMER_W   = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC);

    logic [1:0]          state_reg;
    logic                last_grant_reg;
    logic                gnt_idx_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W/8-1:0] wstrb_reg;
    logic [TIMER_W-1:0]  timer_reg;

    logic arb_idx;
    logic arb_valid;
    logic is_idle;
    logic accept;
    logic wait_done;

    rr_arb2 u_rr_arb2 (
        .req_valid  ({m1_req_valid, m0_req_valid}),
        .last_grant (last_grant_reg),
        .gnt_idx    (arb_idx),
        .gnt_valid  (arb_valid)
    );

    assign is_idle      = (state_reg == ST_IDLE);
    assign m0_req_ready = sys_resetn && is_idle && arb_valid && !arb_idx;
    assign m1_req_ready = sys_resetn && is_idle && arb_valid &&  arb_idx;
    assign accept       = (m0_req_valid && m0_req_ready) || (m1_req_valid && m1_req_ready);

    // A response arriving on the timeout cycle still completes normally; err only
    // fires when the controller stayed silent.
    assign wait_done = (state_reg == ST_WAIT_RSP) && (mem_rsp_valid || (timer_reg == TIMER_MAX));

    assign mem_cmd_valid = (state_reg == ST_ISSUE);
    assign mem_cmd_we    = we_reg;
    assign mem_cmd_addr  = addr_reg;
    assign mem_cmd_wdata = wdata_reg;
    assign mem_cmd_wstrb = wstrb_reg;
    assign busy          = !is_idle;

    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            gnt_idx_reg    <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            timer_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg   <= ST_ISSUE;
                        gnt_idx_reg <= arb_idx;
                        we_reg      <= arb_idx ? m1_req_we    : m0_req_we;
                        addr_reg    <= arb_idx ? m1_req_addr  : m0_req_addr;
                        wdata_reg   <= arb_idx ? m1_req_wdata : m0_req_wdata;
                        wstrb_reg   <= arb_idx ? m1_req_wstrb : m0_req_wstrb;
                    end
                end
                ST_ISSUE: begin
                    if (mem_cmd_ready) begin
                        state_reg <= ST_WAIT_RSP;
                        timer_reg <= '0;
                    end
                end
                ST_WAIT_RSP: begin
                    if (timer_reg != TIMER_MAX) begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                    if (wait_done) begin
                        state_reg      <= ST_IDLE;
                        last_grant_reg <= gnt_idx_reg;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Per-requester response registers, so the idle requester always reads zeros.
    logic                rsp_valid_w [2];
    logic [DATA_W-1:0]   rsp_rdata_w [2];
    logic                rsp_err_w   [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic              rsp_valid_reg;
        logic [DATA_W-1:0] rsp_rdata_reg;
        logic              rsp_err_reg;
        logic              rsp_hit;

        assign rsp_hit = wait_done && (gnt_idx_reg == 1'(gi));

        always_ff @(posedge clk or negedge sys_resetn) begin
            if (!sys_resetn) begin
                rsp_valid_reg <= 1'b0;
                rsp_rdata_reg <= '0;
                rsp_err_reg   <= 1'b0;
            end else begin
                rsp_valid_reg <= rsp_hit;
                rsp_rdata_reg <= (rsp_hit && mem_rsp_valid) ? mem_rsp_rdata : '0;
                rsp_err_reg   <= rsp_hit && !mem_rsp_valid;
            end
        end

        assign rsp_valid_w[gi] = rsp_valid_reg;
        assign rsp_rdata_w[gi] = rsp_rdata_reg;
        assign rsp_err_w[gi]   = rsp_err_reg;
    end

    assign m0_rsp_valid = rsp_valid_w[0];
    assign m0_rsp_rdata = rsp_rdata_w[0];
    assign m0_rsp_err   = rsp_err_w[0];
    assign m1_rsp_valid = rsp_valid_w[1];
    assign m1_rsp_rdata = rsp_rdata_w[1];
    assign m1_rsp_err   = rsp_err_w[1];

endmodule
